// File: rtl/core_io_axi_if.sv
// AXI4-Lite port group between the core IN/OUT bridge (master) and the UART-Lite peripheral (slave).
// Every channel uses valid/ready: a transfer happens on the rising edge where VALID and READY are both high; the
// VALID side keeps address/data stable and never drops VALID before that edge; READY may rise or fall at any time.
interface core_io_axi_if;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/core_io_axi.sv
// AXI4-Lite master that runs the core's IN/OUT instructions against a UART-Lite: polls status,
// then reads the RX FIFO or writes the TX FIFO, holding BUSY until the one-cycle DONE pulse.
module core_io_axi #(
  parameter logic [3:0] ADDR_RX      = 4'h0,
  parameter logic [3:0] ADDR_TX      = 4'h4,
  parameter logic [3:0] ADDR_STAT    = 4'h8,
  parameter int         RX_VALID_BIT = 0,
  parameter int         TX_FULL_BIT  = 3,
  parameter int         POLL_GAP     = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               IN_REQ,
  input  logic               OUT_REQ,
  input  logic [31:0]        OUT_DATA,
  output logic [31:0]        IN_DATA,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [3:0]         DBG_STATE,
  core_io_axi_if.master      s_axi
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ST_AR = 4'd1,
    ST_R  = 4'd2,
    GAP   = 4'd3,
    RX_AR = 4'd4,
    RX_R  = 4'd5,
    TX_AW = 4'd6,
    TX_B  = 4'd7,
    FIN   = 4'd8
  } state_t;

  localparam logic [3:0] GAP_LAST = (POLL_GAP == 0) ? 4'd0 : 4'(POLL_GAP - 1);

  state_t      state_q, state_d;
  logic        op_in_q, op_in_d;
  logic [3:0]  gap_q, gap_d;
  logic        err_acc_q, err_acc_d;
  logic        arvalid_q, arvalid_d;
  logic [3:0]  araddr_q, araddr_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic [3:0]  awaddr_q, awaddr_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstb_q, wstb_d;
  logic        bready_q, bready_d;
  logic [31:0] in_data_q, in_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic r_err, b_err, poll_ok;
  logic unused_bits;

  assign ar_hs   = arvalid_q & s_axi.ARREADY;
  assign r_hs    = rready_q  & s_axi.RVALID;
  assign aw_hs   = awvalid_q & s_axi.AWREADY;
  assign w_hs    = wvalid_q  & s_axi.WREADY;
  assign b_hs    = bready_q  & s_axi.BVALID;
  assign r_err   = (s_axi.RRESP != 2'b00);
  assign b_err   = (s_axi.BRESP != 2'b00);
  // A non-OKAY status response still ends the poll; the sampled bit decides.
  assign poll_ok = op_in_q ? s_axi.RDATA[RX_VALID_BIT] : ~s_axi.RDATA[TX_FULL_BIT];
  assign unused_bits = ^{OUT_DATA[31:8], s_axi.RDATA[31:8]};

  always_comb begin
    state_d   = state_q;
    op_in_d   = op_in_q;
    gap_d     = gap_q;
    err_acc_d = err_acc_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    wvalid_d  = wvalid_q;
    wdata_d   = wdata_q;
    wstb_d    = wstb_q;
    bready_d  = bready_q;
    in_data_d = in_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (IN_REQ || OUT_REQ) begin
          op_in_d   = IN_REQ;
          err_acc_d = 1'b0;
          busy_d    = 1'b1;
          arvalid_d = 1'b1;
          araddr_d  = ADDR_STAT;
          state_d   = ST_AR;
        end
      end
      ST_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (r_hs) begin
          rready_d  = 1'b0;
          err_acc_d = err_acc_q | r_err;
          if (poll_ok && op_in_q) begin
            arvalid_d = 1'b1;
            araddr_d  = ADDR_RX;
            state_d   = RX_AR;
          end else if (poll_ok) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = ADDR_TX;
            wdata_d   = {24'b0, OUT_DATA[7:0]};
            wstb_d    = 4'b0001;
            state_d   = TX_AW;
          end else if (POLL_GAP == 0) begin
            arvalid_d = 1'b1;
            araddr_d  = ADDR_STAT;
            state_d   = ST_AR;
          end else begin
            gap_d     = 4'd0;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          arvalid_d = 1'b1;
          araddr_d  = ADDR_STAT;
          state_d   = ST_AR;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      RX_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RX_R;
        end
      end
      RX_R: begin
        if (r_hs) begin
          rready_d  = 1'b0;
          in_data_d = {24'b0, s_axi.RDATA[7:0]};
          done_d    = 1'b1;
          err_d     = err_acc_q | r_err;
          busy_d    = 1'b0;
          state_d   = FIN;
        end
      end
      TX_AW: begin
        // Address and data channels retire independently, in either order.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || s_axi.AWREADY) && (!wvalid_q || s_axi.WREADY)) begin
          bready_d = 1'b1;
          state_d  = TX_B;
        end
      end
      TX_B: begin
        if (b_hs) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = err_acc_q | b_err;
          busy_d   = 1'b0;
          state_d  = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      op_in_q   <= 1'b0;
      gap_q     <= 4'd0;
      err_acc_q <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= 4'd0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      awaddr_q  <= 4'd0;
      wvalid_q  <= 1'b0;
      wdata_q   <= 32'd0;
      wstb_q    <= 4'd0;
      bready_q  <= 1'b0;
      in_data_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_in_q   <= op_in_d;
      gap_q     <= gap_d;
      err_acc_q <= err_acc_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      wstb_q    <= wstb_d;
      bready_q  <= bready_d;
      in_data_q <= in_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_axi.ARVALID = arvalid_q;
  assign s_axi.ARADDR  = araddr_q;
  assign s_axi.RREADY  = rready_q;
  assign s_axi.AWVALID = awvalid_q;
  assign s_axi.AWADDR  = awaddr_q;
  assign s_axi.WVALID  = wvalid_q;
  assign s_axi.WDATA   = wdata_q;
  assign s_axi.WSTB    = wstb_q;
  assign s_axi.BREADY  = bready_q;
  assign IN_DATA       = in_data_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign DBG_STATE     = state_q;

endmodule
